// File: rtl/key_event_arbiter_if.sv
// Event port between the key arbiter and its consumer: valid/ready handshake
// carrying the index of the channel whose press is being reported.
interface key_event_arbiter_if #(
  parameter int N = 4
);
  localparam int ID_W = $clog2(N);

  logic            event_valid;
  logic [ID_W-1:0] event_id;
  logic            event_ready;

  modport master (output event_valid, output event_id, input event_ready);
  modport slave  (input event_valid, input event_id, output event_ready);
endinterface

// File: rtl/key_event_arbiter.sv
// Pushbutton front end: per-channel synchronizer and debouncer, press-edge
// latching into pending bits, and round-robin serialisation onto one event port.
module key_event_arbiter #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          keys_in,
  output logic [N-1:0]          overrun,
  input  logic                  clear_overrun,
  key_event_arbiter_if.master   ev
);
  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_MAX  = ID_W'(N - 1);

  logic [N-1:0]     sync1_q, sync2_q;
  logic [N-1:0]     stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     overrun_q, overrun_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [N-1:0]     rise;
  logic             slot_free;
  logic             grant_found;
  logic [ID_W-1:0]  grant_id;

  // NOTE: every always_comb output gets a default on entry so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) stable_d[i] = sync2_q[i];
        else                     cnt_d[i]    = cnt_q[i] + 1'b1;
      end
    end
  end

  // Only a newly accepted high level counts as a press; releases are silent.
  assign rise = stable_d & ~stable_q;

  // Rotating priority scan starting at rr_ptr over the pre-edge pending bits.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= N) idx = idx - N;
      if (!grant_found && pending_q[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  assign slot_free = !valid_q || ev.event_ready;

  always_comb begin
    pending_d = pending_q;
    valid_d   = valid_q;
    id_d      = id_q;
    rr_ptr_d  = rr_ptr_q;
    if (slot_free) begin
      if (grant_found) begin
        valid_d             = 1'b1;
        id_d                = grant_id;
        pending_d[grant_id] = 1'b0;
        rr_ptr_d            = (grant_id == ID_MAX) ? '0 : grant_id + 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
    // Applied after the grant clear so a press landing on its own grant edge stays pending.
    pending_d = pending_d | rise;

    overrun_d = clear_overrun ? '0 : overrun_q;
    overrun_d = overrun_d | (rise & pending_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the two synchronizer stages depend on this ordering.
  // NOTE: the debounce counter array is reset along with the rest of the state
  // because a stale count would shorten the first debounce after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      rr_ptr_q  <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
    end else begin
      sync1_q   <= keys_in;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rr_ptr_q  <= rr_ptr_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
    end
  end

  assign ev.event_valid = valid_q;
  assign ev.event_id    = id_q;
  assign overrun        = overrun_q;

endmodule
